// File: rtl/axis_mux_pkg.sv
// Shared types for the AXIS packet mux: beat layout, arbiter states and
// the round-robin pointer advance helper.
package axis_mux_pkg;

   // Default field widths of one merged beat.
   localparam int BEAT_TDATA_WIDTH = 512;
   localparam int BEAT_TDEST_WIDTH = 4;
   localparam int BEAT_TID_WIDTH   = 2;

   // One beat as it travels through the output skid buffer.
   typedef struct packed {
      logic [BEAT_TDATA_WIDTH-1:0] tdata;
      logic                        tlast;
      logic [BEAT_TID_WIDTH-1:0]   tid;
      logic [BEAT_TDEST_WIDTH-1:0] tdest;
   } beat_t;

   // IDLE: combinational round-robin scan. LOCKED: one source owns the port.
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Next round-robin start point after a packet from idx completes.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer. The output is driven straight from a register and
// s_ready depends only on occupancy, so no combinational path links the two
// sides. Two entries are enough to keep 1 beat/clk flowing.
module axis_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
);

   logic [1:0]       count;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic             push;
   logic             pop;

   assign s_ready = (count != 2'd2);
   assign m_valid = (count != 2'd0);
   assign m_data  = head_q;
   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;

   // Occupancy and storage: head is always the oldest beat, tail the second.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head_q <= s_data;
               else               tail_q <= s_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) head_q <= tail_q;
               count <= count - 2'd1;
            end
            // Push and pop together only happens with one entry held
            // (a push needs a free slot, a pop needs a stored beat).
            2'b11: head_q <= s_data;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/axis_packet_mux.sv
// Packet-granular round-robin merge of NUM_INPUTS AXIS streams onto one
// router injection port. A granted packet is never interleaved; out_tid
// carries the source index so the far end can demultiplex.
module axis_packet_mux
   import axis_mux_pkg::*;
#(
   parameter int NUM_INPUTS  = 4,
   parameter int TDATA_WIDTH = BEAT_TDATA_WIDTH,
   parameter int TDEST_WIDTH = BEAT_TDEST_WIDTH,
   parameter int TID_WIDTH   = BEAT_TID_WIDTH
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_INPUTS-1:0]                   in_tvalid,
   output logic [NUM_INPUTS-1:0]                   in_tready,
   input  logic [NUM_INPUTS-1:0][TDATA_WIDTH-1:0]  in_tdata,
   input  logic [NUM_INPUTS-1:0]                   in_tlast,
   input  logic [NUM_INPUTS-1:0][TDEST_WIDTH-1:0]  in_tdest,
   output logic                                    out_tvalid,
   input  logic                                    out_tready,
   output logic [TDATA_WIDTH-1:0]                  out_tdata,
   output logic                                    out_tlast,
   output logic [TID_WIDTH-1:0]                    out_tid,
   output logic [TDEST_WIDTH-1:0]                  out_tdest
);

   localparam int IDX_W = $clog2(NUM_INPUTS);

   if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
      $error("axis_packet_mux: NUM_INPUTS must be in 2..16");
   end
   if (TID_WIDTH < IDX_W) begin : g_bad_tid_width
      $error("axis_packet_mux: TID_WIDTH too narrow for NUM_INPUTS");
   end

   // Beat layout sized by this instance's parameters.
   typedef struct packed {
      logic [TDATA_WIDTH-1:0] tdata;
      logic                   tlast;
      logic [TID_WIDTH-1:0]   tid;
      logic [TDEST_WIDTH-1:0] tdest;
   } mux_beat_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] lock_q, lock_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] scan_idx;
   logic             scan_hit;
   logic [IDX_W-1:0] grant;
   logic             grant_vld;
   logic             buf_ready;
   logic             tready_en;
   logic             accept;
   mux_beat_t        in_beat;
   mux_beat_t        out_beat;

   // First valid source at or after rr_q, wrapping modulo NUM_INPUTS.
   always_comb begin
      cand     = '0;
      scan_idx = '0;
      scan_hit = 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         cand = IDX_W'((int'(rr_q) + k) % NUM_INPUTS);
         if (!scan_hit && in_tvalid[cand]) begin
            scan_hit = 1'b1;
            scan_idx = cand;
         end
      end
   end

   // While locked only the owner is eligible, even if its tvalid drops.
   always_comb begin
      grant     = scan_idx;
      grant_vld = scan_hit;
      if (state_q == LOCKED) begin
         grant     = lock_q;
         grant_vld = 1'b1;
      end
   end

   // Ready is held low during reset and never looks at out_tready.
   assign tready_en = !rst && grant_vld && buf_ready;
   assign accept    = tready_en && in_tvalid[grant];

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ready
      assign in_tready[i] = tready_en && (grant == IDX_W'(i));
   end

   // Lock on a non-last beat, release and advance the pointer on tlast.
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      rr_d    = rr_q;
      if (accept) begin
         if (in_tlast[grant]) begin
            state_d = IDLE;
            rr_d    = IDX_W'(rr_next(int'(grant), NUM_INPUTS));
         end else begin
            state_d = LOCKED;
            lock_d  = grant;
         end
      end
   end

   // Arbiter state; reset drops any lock mid-packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lock_q  <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         rr_q    <= rr_d;
      end
   end

   // Selected source's beat, stamped with its index.
   always_comb begin
      in_beat.tdata = in_tdata[grant];
      in_beat.tlast = in_tlast[grant];
      in_beat.tid   = TID_WIDTH'(grant);
      in_beat.tdest = in_tdest[grant];
   end

   axis_skid_buffer #(
      .WIDTH ($bits(mux_beat_t))
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .s_valid (accept),
      .s_ready (buf_ready),
      .s_data  (in_beat),
      .m_valid (out_tvalid),
      .m_ready (out_tready),
      .m_data  (out_beat)
   );

   assign out_tdata = out_beat.tdata;
   assign out_tlast = out_beat.tlast;
   assign out_tid   = out_beat.tid;
   assign out_tdest = out_beat.tdest;

endmodule

// File: tb/tb_axis_packet_mux.sv
// Directed bench for axis_packet_mux: per-source beat memories drive the
// inputs, expected beats go into a scoreboard queue, and a monitor pops and
// compares on every output handshake, also checking stall stability.
module tb_axis_packet_mux;

   localparam int N    = 4;
   localparam int DW   = 32;
   localparam int DSTW = 4;
   localparam int TIDW = 2;

   typedef struct packed {
      logic [DW-1:0]   d;
      logic            last;
      logic [DSTW-1:0] dest;
   } sbeat_t;

   typedef struct packed {
      logic [DW-1:0]   d;
      logic            last;
      logic [TIDW-1:0] tid;
      logic [DSTW-1:0] dest;
   } exp_t;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic [N-1:0]              in_tvalid = '0;
   logic [N-1:0]              in_tready;
   logic [N-1:0][DW-1:0]      in_tdata = '0;
   logic [N-1:0]              in_tlast = '0;
   logic [N-1:0][DSTW-1:0]    in_tdest = '0;
   logic                      out_tvalid;
   logic                      out_tready = 1'b1;
   logic [DW-1:0]             out_tdata;
   logic                      out_tlast;
   logic [TIDW-1:0]           out_tid;
   logic [DSTW-1:0]           out_tdest;

   sbeat_t       src_mem [N][64];
   int           src_wr [N];
   int           src_rd [N];
   logic [N-1:0] pause = '0;
   logic [N-1:0] flush = '0;
   exp_t         exp_q [$];
   int           acc_log [$];
   int           hs_log [$];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   axis_packet_mux #(
      .NUM_INPUTS  (N),
      .TDATA_WIDTH (DW),
      .TDEST_WIDTH (DSTW),
      .TID_WIDTH   (TIDW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .in_tdata   (in_tdata),
      .in_tlast   (in_tlast),
      .in_tdest   (in_tdest),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .out_tdata  (out_tdata),
      .out_tlast  (out_tlast),
      .out_tid    (out_tid),
      .out_tdest  (out_tdest)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic load_pkt(input int s, input int n, input logic [DSTW-1:0] dest, input logic [DW-1:0] base);
      for (int j = 0; j < n; j++) begin
         src_mem[s][src_wr[s]] = '{d: base + DW'(j), last: (j == n - 1), dest: dest};
         src_wr[s]++;
      end
   endtask

   task automatic expect_pkt(input int s, input int n, input logic [DSTW-1:0] dest, input logic [DW-1:0] base);
      for (int j = 0; j < n; j++)
         exp_q.push_back('{d: base + DW'(j), last: (j == n - 1), tid: TIDW'(s), dest: dest});
   endtask

   function automatic bit busy();
      bit b = (exp_q.size() != 0);
      for (int i = 0; i < N; i++)
         if (src_rd[i] < src_wr[i]) b = 1'b1;
      return b;
   endfunction

   task automatic drain(input string name, input int budget);
      int k = 0;
      while (busy() && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (busy()) begin
         errors++;
         $display("FAIL %s: timeout after %0d cycles, %0d beats still expected", name, budget, exp_q.size());
         exp_q.delete();
      end
      tick();
   endtask

   // One lone beat from source 3 leaves the round-robin pointer at 0.
   task automatic park_rr(input logic [DW-1:0] base);
      load_pkt(3, 1, 4'd0, base);
      expect_pkt(3, 1, 4'd0, base);
      drain("park", 20);
   endtask

   // Source driver: retire accepted beats at the edge, present the next one after it.
   initial begin
      forever begin
         @(posedge clk);
         for (int i = 0; i < N; i++) begin
            if (in_tvalid[i] && in_tready[i]) begin
               src_rd[i]++;
               acc_log.push_back(cyc);
            end
            if (flush[i]) src_rd[i] = src_wr[i];
         end
         cyc++;
         #1;
         for (int i = 0; i < N; i++) begin
            if (src_rd[i] < src_wr[i] && !pause[i]) begin
               in_tvalid[i] = 1'b1;
               in_tdata[i]  = src_mem[i][src_rd[i]].d;
               in_tlast[i]  = src_mem[i][src_rd[i]].last;
               in_tdest[i]  = src_mem[i][src_rd[i]].dest;
            end else begin
               in_tvalid[i] = 1'b0;
               in_tlast[i]  = 1'b0;
            end
         end
      end
   end

   // Output monitor: scoreboard pop on handshake, hold check while stalled.
   initial begin
      exp_t cur;
      exp_t prev;
      exp_t want;
      bit   prev_stall = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = '{d: out_tdata, last: out_tlast, tid: out_tid, dest: out_tdest};
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid_hold", 64'(out_tvalid), 64'(1));
               check("stall_fields_hold", 64'(cur), 64'(prev));
            end
            if (out_tvalid && out_tready) begin
               hs_log.push_back(cyc);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got %0h expected no beat", cur);
               end else begin
                  want = exp_q.pop_front();
                  check("out_beat", 64'(cur), 64'(want));
               end
            end
            prev_stall = out_tvalid && !out_tready;
            prev       = cur;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int na;
      int nh;
      int b;
      int k;

      // Reset with source 1 already offering a beat: nothing may be accepted.
      load_pkt(1, 1, 4'd7, 32'h1000);
      expect_pkt(1, 1, 4'd7, 32'h1000);
      tick();
      tick();
      check("rst_out_tvalid", 64'(out_tvalid), 64'(0));
      check("rst_in_tready", 64'(in_tready), 64'(0));
      check("rst_out_fields", 64'({out_tdata, out_tlast, out_tid, out_tdest}), 64'(0));
      rst = 1'b0;
      drain("reset_pkt", 20);

      // Single source 2, 3-beat packet: latency 1, back to back.
      na = acc_log.size();
      nh = hs_log.size();
      load_pkt(2, 3, 4'd5, 32'h2000);
      expect_pkt(2, 3, 4'd5, 32'h2000);
      drain("single_src", 20);
      if (hs_log.size() >= nh + 3 && acc_log.size() > na) begin
         check("first_beat_latency", 64'(hs_log[nh] - acc_log[na]), 64'(1));
         check("three_beat_span", 64'(hs_log[nh + 2] - hs_log[nh]), 64'(2));
      end else begin
         check("single_src_beats", 64'(hs_log.size() - nh), 64'(3));
      end

      // Pointer now 3: source 3 beats source 0.
      load_pkt(0, 1, 4'd1, 32'h3000);
      load_pkt(3, 1, 4'd2, 32'h3300);
      expect_pkt(3, 1, 4'd2, 32'h3300);
      expect_pkt(0, 1, 4'd1, 32'h3000);
      drain("rr_after_src2", 20);
      park_rr(32'h3f00);

      // Sources 0 and 1, 4-beat packets each: no interleaving.
      load_pkt(0, 4, 4'd3, 32'h4000);
      load_pkt(1, 4, 4'd4, 32'h4100);
      expect_pkt(0, 4, 4'd3, 32'h4000);
      expect_pkt(1, 4, 4'd4, 32'h4100);
      drain("two_packets", 30);
      park_rr(32'h4f00);

      // All four sources, three 1-beat packets each: tid 0,1,2,3 repeating, no bubbles.
      nh = hs_log.size();
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < N; s++) begin
            load_pkt(s, 1, DSTW'(s), 32'h5000 + DW'(r * 16 + s));
            expect_pkt(s, 1, DSTW'(s), 32'h5000 + DW'(r * 16 + s));
         end
      drain("round_robin", 40);
      if (hs_log.size() >= nh + 12)
         check("rr_no_bubbles", 64'(hs_log[nh + 11] - hs_log[nh]), 64'(11));
      else
         check("rr_beats", 64'(hs_log.size() - nh), 64'(12));

      // Downstream stall while source 3 streams: exactly two beats taken.
      out_tready = 1'b0;
      b = src_rd[3];
      load_pkt(3, 4, 4'd9, 32'h6000);
      expect_pkt(3, 4, 4'd9, 32'h6000);
      repeat (6) tick();
      check("stall_accepted", 64'(src_rd[3] - b), 64'(2));
      check("stall_in_tready3", 64'(in_tready[3]), 64'(0));
      check("stall_out_tvalid", 64'(out_tvalid), 64'(1));
      check("stall_out_tdata", 64'(out_tdata), 64'(32'h6000));
      out_tready = 1'b1;
      drain("stall_release", 20);

      // Source 1 locked, drops tvalid for 5 cycles while source 0 waits.
      b = src_rd[1];
      load_pkt(1, 4, 4'd6, 32'h7000);
      expect_pkt(1, 4, 4'd6, 32'h7000);
      expect_pkt(0, 1, 4'd8, 32'h7100);
      k = 0;
      while (src_rd[1] - b < 2 && k < 20) begin
         tick();
         k++;
      end
      check("lock_reached", 64'(src_rd[1] - b), 64'(2));
      pause[1] = 1'b1;
      load_pkt(0, 1, 4'd8, 32'h7100);
      repeat (5) begin
         tick();
         check("locked_src0_ready", 64'(in_tready[0]), 64'(0));
      end
      pause[1] = 1'b0;
      drain("lock_hold", 30);

      // Reset mid-packet with two beats buffered.
      out_tready = 1'b0;
      b = src_rd[2];
      load_pkt(2, 4, 4'd10, 32'h8000);
      k = 0;
      while ((src_rd[2] - b < 2 || in_tready[2]) && k < 20) begin
         tick();
         k++;
      end
      check("prereset_buffered", 64'(src_rd[2] - b), 64'(2));
      check("prereset_out_tvalid", 64'(out_tvalid), 64'(1));
      rst = 1'b1;
      flush[2] = 1'b1;
      #1;
      check("async_rst_out_tvalid", 64'(out_tvalid), 64'(0));
      check("async_rst_in_tready", 64'(in_tready), 64'(0));
      tick();
      rst = 1'b0;
      flush[2] = 1'b0;
      out_tready = 1'b1;
      load_pkt(0, 1, 4'd1, 32'h9000);
      load_pkt(3, 1, 4'd2, 32'h9300);
      expect_pkt(0, 1, 4'd1, 32'h9000);
      expect_pkt(3, 1, 4'd2, 32'h9300);
      drain("post_reset", 20);
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
